endp_flit_injector: RTL and testbench

ENDP_FLIT_INJECTOR -- requirements
Module: endp_flit_injector

---
 rtl/endp_flit_injector.sv | 118 +++++++++++
 tb/tb_endp_flit_injector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/endp_flit_injector.sv
// endp_flit_injector: turns packet requests plus body words into credit-paced flits
// for one router input port, with one credit counter per virtual channel.
module endp_flit_injector #(
   parameter int V           = 2,
   parameter int B           = 4,
   parameter int Fpay        = 32,
   parameter int DSTw        = 8,
   parameter int MAX_PCK_LEN = 16,
   localparam int VCW        = (V > 1) ? $clog2(V) : 1,
   localparam int LENW       = $clog2(MAX_PCK_LEN) + 1,
   localparam int CW         = $clog2(B) + 1,
   localparam int FW         = 2 + V + Fpay
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pck_valid,
   output logic             pck_ready,
   input  logic [DSTw-1:0]  pck_dest,
   input  logic [VCW-1:0]   pck_vc,
   input  logic [LENW-1:0]  pck_len,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic [Fpay-1:0]  data_in,
   output logic             flit_out_wr,
   output logic [FW-1:0]    flit_out,
   input  logic [V-1:0]     credit_in,
   output logic             credit_err
);
   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
   localparam logic [LENW-1:0] MAXL = LENW'(MAX_PCK_LEN);
   localparam logic [LENW-1:0] ONE  = LENW'(1);

   state_t            state_q, state_d;
   logic [DSTw-1:0]   dest_q, dest_d;
   logic [VCW-1:0]    vc_q, vc_d;
   logic [LENW-1:0]   len_q, len_d, idx_q, idx_d, eff;
   logic [CW-1:0]     cred_q [V];
   logic [CW-1:0]     cred_d [V];
   logic              err_q, err_d, wr_q, wr_d, en_q, en_d, issue, cred_ok;
   logic [FW-1:0]     flit_q, flit_d;
   logic [V-1:0]      vc_oh;

   always_comb begin
      state_d    = state_q;
      dest_d     = dest_q;
      vc_d       = vc_q;
      len_d      = len_q;
      idx_d      = idx_q;
      flit_d     = flit_q;
      err_d      = err_q;
      en_d       = 1'b1;
      issue      = 1'b0;
      vc_oh      = V'(1) << vc_q;
      cred_ok    = cred_q[vc_q] != '0;
      eff        = (pck_len == '0) ? ONE : (pck_len > MAXL) ? MAXL : pck_len;
      // pck_ready waits for the first edge after reset release via en_q
      pck_ready  = en_q && state_q == IDLE;
      data_ready = state_q == BODY && cred_ok;
      if (pck_valid && pck_ready) begin
         dest_d  = pck_dest;
         vc_d    = pck_vc;
         len_d   = eff;
         state_d = HEAD;
      end
      if (state_q == HEAD && cred_ok) begin
         issue   = 1'b1;
         flit_d  = {1'b1, len_q == ONE, vc_oh, Fpay'({len_q, dest_q})};
         idx_d   = ONE;
         state_d = (len_q == ONE) ? IDLE : BODY;
      end
      if (data_ready && data_valid) begin
         issue   = 1'b1;
         flit_d  = {1'b0, idx_q == len_q - ONE, vc_oh, data_in};
         idx_d   = idx_q + ONE;
         state_d = (idx_q == len_q - ONE) ? IDLE : BODY;
      end
      wr_d = issue;
      for (int i = 0; i < V; i++) begin
         cred_d[i] = cred_q[i];
         if (credit_in[i] && !(issue && vc_q == VCW'(i))) begin
            if (cred_q[i] == CW'(B)) err_d = 1'b1;
            else cred_d[i] = cred_q[i] + CW'(1);
         end else if (!credit_in[i] && issue && vc_q == VCW'(i)) begin
            cred_d[i] = cred_q[i] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         dest_q  <= '0;
         vc_q    <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         flit_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         en_q    <= 1'b0;
         for (int i = 0; i < V; i++) cred_q[i] <= CW'(B);
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         vc_q    <= vc_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         flit_q  <= flit_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         en_q    <= en_d;
         for (int i = 0; i < V; i++) cred_q[i] <= cred_d[i];
      end
   end

   assign flit_out    = flit_q;
   assign flit_out_wr = wr_q;
   assign credit_err  = err_q;
endmodule

// File: tb/tb_endp_flit_injector.sv
// tb_endp_flit_injector: directed traffic against a flit-queue and credit model.
module tb_endp_flit_injector;
   logic        clk = 0, rst_n = 1, pck_valid = 0, data_valid = 0;
   logic        pck_ready, data_ready, flit_out_wr, credit_err;
   logic [7:0]  pck_dest = 0;
   logic        pck_vc = 0;
   logic [4:0]  pck_len = 0;
   logic [31:0] data_in = 0;
   logic [1:0]  credit_in = 0, cin_s = 0;
   logic [35:0] flit_out;
   int          vectors = 0, errors = 0, nflits = 0, wcount = 0, wnext = 0, cur_vc = 0;
   int          cnt [2] = '{4, 4};
   logic        err_m = 0, hs = 0, auto_ret = 0;
   logic [35:0] exp_q [$];

   endp_flit_injector dut (
      .clk(clk), .reset(rst_n), .pck_valid(pck_valid), .pck_ready(pck_ready),
      .pck_dest(pck_dest), .pck_vc(pck_vc), .pck_len(pck_len),
      .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
      .flit_out_wr(flit_out_wr), .flit_out(flit_out),
      .credit_in(credit_in), .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", n, a, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      exp_q.delete();
      cnt = '{4, 4};
      err_m = 0; cin_s = 0; hs = 0; wcount = 0; wnext = 0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 0;
      model_reset();
      #1;
      chk("rst_wr", flit_out_wr, 0);
      chk("rst_flit", flit_out, 0);
      chk("rst_err", credit_err, 0);
      chk("rst_pck_ready", pck_ready, 0);
      chk("rst_data_ready", data_ready, 0);
      repeat (n) tick;
      rst_n = 1;
      #1 chk("release_pck_ready", pck_ready, 0);
      tick;
      chk("post_edge_pck_ready", pck_ready, 1);
   endtask

   // Expected flits come straight from the packet rules: head then in-order body words.
   task automatic send(input logic [7:0] d, input int vc, input int len);
      int i, eff;
      logic [1:0] oh;
      pck_dest = d; pck_vc = vc[0]; pck_len = len[4:0]; pck_valid = 1;
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (pck_ready) break;
      end
      chk("pck_ready_wait", i < 100, 1);
      eff = (len == 0) ? 1 : (len > 16) ? 16 : len;
      oh = 2'b01 << vc;
      exp_q.push_back({1'b1, eff == 1, oh, 32'((eff << 8) | d)});
      for (int j = 1; j < eff; j++) begin
         exp_q.push_back({1'b0, j == eff - 1, oh, 32'hD000_0000 + 32'(wnext)});
         wnext++;
      end
      cur_vc = vc;
      tick;
      pck_valid = 0;
   endtask

   task automatic pulse(input logic [1:0] m, input int n);
      repeat (n) begin
         credit_in = m; tick;
         credit_in = 0; tick;
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n && exp_q.size() > 0; i++) tick;
      chk("drain", exp_q.size(), 0);
      tick; tick;
   endtask

   always @(posedge clk) begin
      #1;
      if (hs) begin wcount++; hs = 0; end
      data_in = 32'hD000_0000 + 32'(wcount);
      if (auto_ret) credit_in = flit_out_wr ? flit_out[33:32] : 2'b00;
   end

   // cnt holds each VC's credit at the start of the previous cycle; it is advanced
   // here using that cycle's credit_in and the flit it issued (visible now).
   always @(negedge clk) begin
      int vv;
      logic [35:0] e;
      if (flit_out_wr === 1'b1) begin
         vv = flit_out[33] ? 1 : 0;
         nflits++;
         if (exp_q.size() == 0) chk("unexpected_flit", flit_out_wr, 0);
         else begin
            e = exp_q.pop_front();
            chk("flit", flit_out, e);
         end
         chk("issue_credit", cnt[vv] > 0, 1);
      end
      for (int v = 0; v < 2; v++) begin
         logic inc, dec;
         inc = cin_s[v];
         dec = flit_out_wr === 1'b1 && vv == v;
         if (inc && !dec) begin
            if (cnt[v] == 4) err_m = 1;
            else cnt[v]++;
         end else if (dec && !inc) cnt[v]--;
      end
      chk("credit_err", credit_err, err_m);
      if (data_ready === 1'b1) chk("ready_credit", cnt[cur_vc] > 0, 1);
      cin_s = credit_in;
      hs = data_valid && data_ready;
   end

   initial begin
      #2 do_reset(3);
      data_valid = 1;
      send(8'd5, 1, 1);
      chk("head_cycle_ready", pck_ready, 0);
      tick;
      chk("single_wr", flit_out_wr, 1);
      chk("single_flit", flit_out, 36'hE00000105);
      chk("idle_after_2", pck_ready, 1);
      pulse(2'b10, 1);
      nflits = 0;
      send(8'h11, 0, 6);
      repeat (12) tick;
      chk("stall_count", nflits, 4);
      chk("stall_ready", data_ready, 0);
      pulse(2'b01, 1);
      repeat (4) tick;
      chk("fifth_flit", nflits, 5);
      pulse(2'b01, 1);
      repeat (4) tick;
      chk("tail_count", nflits, 6);
      chk("stall_drained", exp_q.size(), 0);
      pulse(2'b01, 2);
      send(8'h22, 0, 2);
      credit_in = 2'b01;
      tick;
      credit_in = 0;
      drain(20);
      nflits = 0;
      send(8'h23, 0, 3);
      repeat (8) tick;
      chk("one_credit_left", nflits, 1);
      pulse(2'b01, 2);
      drain(20);
      pulse(2'b01, 4);
      send(8'h33, 0, 0);
      tick;
      chk("len0_flit", flit_out, 36'hD00000133);
      drain(20);
      pulse(2'b01, 1);
      auto_ret = 1;
      nflits = 0;
      send(8'h44, 1, 20);
      drain(100);
      chk("len20_count", nflits, 16);
      repeat (3) tick;
      nflits = 0;
      send(8'h01, 0, 3);
      send(8'h02, 1, 3);
      drain(50);
      chk("b2b_count", nflits, 6);
      repeat (3) tick;
      auto_ret = 0;
      tick;
      credit_in = 0;
      credit_in = 2'b10;
      tick;
      credit_in = 0;
      chk("overflow_err", credit_err, 1);
      tick;
      chk("err_sticky", credit_err, 1);
      nflits = 0;
      send(8'h55, 0, 5);
      for (int i = 0; i < 20 && nflits < 2; i++) tick;
      chk("mid_two_flits", nflits, 2);
      do_reset(2);
      nflits = 0;
      send(8'h66, 0, 4);
      drain(30);
      send(8'h77, 1, 4);
      drain(30);
      chk("post_reset_full", nflits, 8);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
